// File: rtl/fifo_credit_sender_pkg.sv
// Shared types and helpers for the credit-flow sender.
package fifo_pkg;

    typedef enum logic [0:0] {CS_RUN, CS_DRAIN} credit_state_t;

    function automatic int unsigned credit_width(input int unsigned max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/fifo_credit_sender_if.sv
// Producer handshake and link-side signals of the credit sender.
// master = producer/receiver environment, slave = the sender.
interface fifo_credit_sender_if #(
    parameter int unsigned DATA_WIDTH = 64
) ();

    logic                  data_in_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_ready;
    logic                  data_out_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  credit_return;

    modport master (
        output data_in_valid,
        output data_in,
        output credit_return,
        input  data_in_ready,
        input  data_out_valid,
        input  data_out
    );

    modport slave (
        input  data_in_valid,
        input  data_in,
        input  credit_return,
        output data_in_ready,
        output data_out_valid,
        output data_out
    );

endinterface

// File: rtl/fifo_credit_sender_credit_counter.sv
// Up/down credit counter, reset to MAX, saturating at MAX on an unmatched return.
module credit_counter
    import fifo_pkg::*;
#(
    parameter int unsigned MAX          = 3,
    parameter int unsigned CREDIT_WIDTH = credit_width(MAX)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i__dec,
    input  logic                    i__inc,
    output logic [CREDIT_WIDTH-1:0] o__count,
    output logic [CREDIT_WIDTH-1:0] o__count__next,
    output logic                    o__at_max,
    output logic                    o__ovf_event
);

    localparam logic [CREDIT_WIDTH-1:0] MaxCount = CREDIT_WIDTH'(MAX);

    logic [CREDIT_WIDTH-1:0] count_q, count_d;

    assign o__at_max    = (count_q == MaxCount);
    assign o__ovf_event = i__inc & ~i__dec & o__at_max;

    // Simultaneous inc and dec cancel; decrement at zero cannot occur since push is gated.
    always_comb begin
        count_d = count_q;
        if (i__inc & ~i__dec & ~o__at_max) begin
            count_d = count_q + 1'b1;
        end else if (i__dec & ~i__inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= MaxCount;
        end else begin
            count_q <= count_d;
        end
    end

    assign o__count       = count_q;
    assign o__count__next = count_d;

endmodule

// File: rtl/fifo_credit_sender.sv
// Credit-flow transmit stage feeding a remote FWFT FIFO through a registered output.
// Optional sticky overflow flag: define FIFO_CREDIT_SENDER_OVF_CHECK_EN.
module fifo_credit_sender
    import fifo_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH   = 64,
    parameter int unsigned  MAX_CREDITS  = 3,
    localparam int unsigned CREDIT_WIDTH = credit_width(MAX_CREDITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    fifo_credit_sender_if.slave     bus,
    input  logic                    i__drain,
    output logic                    o__drain_done,
    output logic [CREDIT_WIDTH-1:0] o__credit_count,
    output logic                    o__credit_overflow
);

    credit_state_t         state_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    logic                    ready;
    logic                    push;
    logic                    at_max;
    logic                    ovf_event;
    logic [CREDIT_WIDTH-1:0] credit;
    logic [CREDIT_WIDTH-1:0] unused_credit_next;

    credit_counter #(
        .MAX          (MAX_CREDITS),
        .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_credit_counter (
        .clk            (clk),
        .reset          (reset),
        .i__dec         (push),
        .i__inc         (bus.credit_return),
        .o__count       (credit),
        .o__count__next (unused_credit_next),
        .o__at_max      (at_max),
        .o__ovf_event   (ovf_event)
    );

    // Ready is built from registered state only so it can cross to a slow producer.
    assign ready = (state_q == CS_RUN) & (credit != '0) & ~reset;
    assign push  = bus.data_in_valid & ready;

    assign o__drain_done = (state_q == CS_DRAIN) & at_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CS_RUN;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            out_valid_q <= push;
            if (push) begin
                data_out_q <= bus.data_in;
            end
            unique case (state_q)
                CS_RUN:   if (i__drain) state_q <= CS_DRAIN;
                CS_DRAIN: if (at_max)   state_q <= CS_RUN;
            endcase
        end
    end

    assign bus.data_in_ready  = ready;
    assign bus.data_out_valid = out_valid_q;
    assign bus.data_out       = data_out_q;
    assign o__credit_count    = credit;

`ifdef FIFO_CREDIT_SENDER_OVF_CHECK_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_event) begin
            ovf_q <= 1'b1;
        end
    end

    assign o__credit_overflow = ovf_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && ovf_event) begin
            $error("credit returned while credit count already at maximum");
        end
    end
`endif
`else
    logic unused_ovf_event;
    assign unused_ovf_event   = ovf_event;
    assign o__credit_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_credit_sender.sv
// Self-checking bench for fifo_credit_sender: directed table, corner sequences, random vs model.
module tb_fifo_credit_sender;

    localparam int unsigned DW  = 8;
    localparam int unsigned MAX = 4;
    localparam int unsigned CW  = 3;
`ifdef FIFO_CREDIT_SENDER_OVF_CHECK_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          drain;
    logic          drain_done;
    logic [CW-1:0] credit_count;
    logic          overflow;

    fifo_credit_sender_if #(.DATA_WIDTH(DW)) bus ();

    fifo_credit_sender #(
        .DATA_WIDTH  (DW),
        .MAX_CREDITS (MAX)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus.slave),
        .i__drain           (drain),
        .o__drain_done      (drain_done),
        .o__credit_count    (credit_count),
        .o__credit_overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: credits available, draining flag, last launched word.
    int          m_cred;
    bit          m_drain;
    bit          m_ovf;
    bit          m_ov;
    logic [7:0]  m_out;

    bit          cur_v, cur_ret, cur_dr, cur_rst;
    logic [7:0]  cur_d;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         ret;
        bit         dr;
        bit         e_rdy;
        bit         e_ov;
        logic [7:0] e_out;
        int         e_cnt;
        bit         e_done;
    } vec_t;

    vec_t tbl[20];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_cred  = MAX;
        m_drain = 1'b0;
        m_ovf   = 1'b0;
        m_ov    = 1'b0;
        m_out   = 8'h00;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit ret, input bit dr,
                         input bit rst);
        bit exp_ready;
        bit exp_done;
        cur_v = v; cur_d = d; cur_ret = ret; cur_dr = dr; cur_rst = rst;
        bus.data_in_valid = v;
        bus.data_in       = d;
        bus.credit_return = ret;
        drain             = dr;
        reset             = rst;
        #1;
        exp_ready = !m_drain && (m_cred != 0) && !rst;
        exp_done  = m_drain && (m_cred == MAX);
        check("ready",     64'(bus.data_in_ready),  64'(exp_ready));
        check("done",      64'(drain_done),         64'(exp_done));
        check("count",     64'(credit_count),       64'(m_cred));
        check("out_valid", 64'(bus.data_out_valid), 64'(m_ov));
        check("data_out",  64'(bus.data_out),       64'(m_out));
        check("overflow",  64'(overflow),           64'(m_ovf));
    endtask

    task automatic tick();
        bit push;
        bit done;
        int nc;
        @(posedge clk);
        if (cur_rst) begin
            model_reset();
        end else begin
            push  = cur_v && !m_drain && (m_cred != 0);
            done  = m_drain && (m_cred == MAX);
            m_ov  = push;
            if (push) m_out = cur_d;
            nc = m_cred - int'(push) + int'(cur_ret);
            if (nc > MAX) begin
                nc = MAX;
                if (OvfEn) m_ovf = 1'b1;
            end
            m_cred = nc;
            if (done) m_drain = 1'b0;
            else if (!m_drain && cur_dr) m_drain = 1'b1;
        end
        #1;
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit ret, input bit dr,
                         input bit rst);
        drive(v, d, ret, dr, rst);
        tick();
    endtask

    initial begin
        bus.data_in_valid = 1'b0;
        bus.data_in       = '0;
        bus.credit_return = 1'b0;
        drain             = 1'b0;
        reset             = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cycle(0, 8'h00, 0, 0, 1);

        // Backpressure at zero credits, then push+return at credit 1.
        tbl[0]  = '{1, 8'hA0, 0, 0, 1, 0, 8'h00, 4, 0};
        tbl[1]  = '{1, 8'hA1, 0, 0, 1, 1, 8'hA0, 3, 0};
        tbl[2]  = '{1, 8'hA2, 0, 0, 1, 1, 8'hA1, 2, 0};
        tbl[3]  = '{1, 8'hA3, 0, 0, 1, 1, 8'hA2, 1, 0};
        tbl[4]  = '{1, 8'hA4, 0, 0, 0, 1, 8'hA3, 0, 0};
        tbl[5]  = '{0, 8'h00, 0, 0, 0, 0, 8'hA3, 0, 0};
        tbl[6]  = '{0, 8'h00, 1, 0, 0, 0, 8'hA3, 0, 0};
        tbl[7]  = '{0, 8'h00, 1, 0, 1, 0, 8'hA3, 1, 0};
        tbl[8]  = '{0, 8'h00, 1, 0, 1, 0, 8'hA3, 2, 0};
        tbl[9]  = '{0, 8'h00, 1, 0, 1, 0, 8'hA3, 3, 0};
        tbl[10] = '{0, 8'h00, 0, 0, 1, 0, 8'hA3, 4, 0};
        tbl[11] = '{1, 8'hB0, 0, 0, 1, 0, 8'hA3, 4, 0};
        tbl[12] = '{1, 8'hB1, 0, 0, 1, 1, 8'hB0, 3, 0};
        tbl[13] = '{1, 8'hB2, 0, 0, 1, 1, 8'hB1, 2, 0};
        tbl[14] = '{1, 8'hB3, 1, 0, 1, 1, 8'hB2, 1, 0};
        tbl[15] = '{0, 8'h00, 0, 0, 1, 1, 8'hB3, 1, 0};
        tbl[16] = '{0, 8'h00, 1, 0, 1, 0, 8'hB3, 1, 0};
        tbl[17] = '{0, 8'h00, 1, 0, 1, 0, 8'hB3, 2, 0};
        tbl[18] = '{0, 8'h00, 1, 0, 1, 0, 8'hB3, 3, 0};
        tbl[19] = '{0, 8'h00, 0, 0, 1, 0, 8'hB3, 4, 0};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].ret, tbl[i].dr, 0);
            check($sformatf("tbl%0d_ready", i), 64'(bus.data_in_ready), 64'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_ovalid", i), 64'(bus.data_out_valid), 64'(tbl[i].e_ov));
            check($sformatf("tbl%0d_out", i), 64'(bus.data_out), 64'(tbl[i].e_out));
            check($sformatf("tbl%0d_count", i), 64'(credit_count), 64'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_done", i), 64'(drain_done), 64'(tbl[i].e_done));
            tick();
        end

        // Drain with two outstanding; returns arrive 3 and 5 cycles after the pulse.
        cycle(1, 8'hC0, 0, 0, 0);
        cycle(1, 8'hC1, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'hC2 + 8'(i), (i == 2 || i == 4), 1, 0);
            check("t3_ready_low", 64'(bus.data_in_ready), 64'(0));
            check("t3_done", 64'(drain_done), 64'(i == 5));
            tick();
        end
        drive(0, 8'h00, 0, 0, 0);
        check("t3_ready_back", 64'(bus.data_in_ready), 64'(1));
        check("t3_count", 64'(credit_count), 64'(4));
        tick();

        // Drain with all credits home: single-cycle DRAIN.
        cycle(0, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 0);
        check("t3b_done", 64'(drain_done), 64'(1));
        tick();
        drive(0, 8'h00, 0, 0, 0);
        check("t3b_ready", 64'(bus.data_in_ready), 64'(1));
        tick();

        // Return at full credit saturates.
        cycle(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 0, 0, 0);
        check("t4_count", 64'(credit_count), 64'(4));
        check("t4_ovf", 64'(overflow), 64'(OvfEn));
        tick();
        drive(0, 8'h00, 0, 0, 0);
        check("t4_ovf_sticky", 64'(overflow), 64'(OvfEn));
        tick();

        // Reset during DRAIN with three outstanding, a return discarded by reset.
        cycle(1, 8'hD0, 0, 0, 0);
        cycle(1, 8'hD1, 0, 0, 0);
        cycle(1, 8'hD2, 0, 1, 0);
        cycle(0, 8'h00, 0, 0, 0);
        drive(1, 8'hD3, 1, 0, 1);
        check("t5_ready_in_reset", 64'(bus.data_in_ready), 64'(0));
        tick();
        drive(0, 8'h00, 0, 0, 0);
        check("t5_count", 64'(credit_count), 64'(4));
        check("t5_ovalid", 64'(bus.data_out_valid), 64'(0));
        check("t5_done", 64'(drain_done), 64'(0));
        check("t5_ready", 64'(bus.data_in_ready), 64'(1));
        check("t5_ovf", 64'(overflow), 64'(0));
        tick();

        // Random traffic; the receiver only returns credits it actually owes.
        for (int i = 0; i < 500; i++) begin
            cycle(bit'($urandom_range(0, 1)), 8'($urandom),
                  (m_cred < MAX) && ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 96) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
